// File: rtl/imem_port_arbiter_if.sv
// Bundle of the two requester ports and the instruction-memory read port.
// The arbiter uses the slave modport; requesters and the memory sit on master.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              lock0;
  logic              gnt0;
  logic [DATA_W-1:0] rdata0;
  logic              rvalid0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              lock1;
  logic              gnt1;
  logic [DATA_W-1:0] rdata1;
  logic              rvalid1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              err;

  modport slave (
    input  req0, addr0, lock0, req1, addr1, lock1, mem_rdata,
    output gnt0, rdata0, rvalid0, gnt1, rdata1, rvalid1, mem_addr, err
  );

  modport master (
    output req0, addr0, lock0, req1, addr1, lock1, mem_rdata,
    input  gnt0, rdata0, rvalid0, gnt1, rdata1, rvalid1, mem_addr, err
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter for the instruction-memory read port with bounded lock bursts
// and a registered 1-cycle response. Define IMEM_ARB_ALIGN_CHECK_EN for misalignment flagging.
module imem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  imem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;

  logic              gnt0_w, gnt1_w;
  logic              owner_hold;
  logic              granted_lock;
  logic [3:0]        cnt_inc;
  logic [ADDR_W-1:0] mem_addr_w;
  logic [DATA_W-1:0] resp_word;
  logic              err_d;

  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              err_q;

  assign owner_hold = ((state_q == OWN0) && bus.req0) ||
                      ((state_q == OWN1) && bus.req1);

  // Owner keeps the port while requesting; otherwise plain round-robin against last_q.
  always_comb begin
    gnt0_w = 1'b0;
    gnt1_w = 1'b0;
    if (!reset_n) begin
      gnt0_w = 1'b0;
      gnt1_w = 1'b0;
    end else if ((state_q == OWN0) && bus.req0) begin
      gnt0_w = 1'b1;
    end else if ((state_q == OWN1) && bus.req1) begin
      gnt1_w = 1'b1;
    end else if (bus.req0 && bus.req1) begin
      gnt0_w = last_q;
      gnt1_w = ~last_q;
    end else begin
      gnt0_w = bus.req0;
      gnt1_w = bus.req1;
    end
  end

  assign granted_lock = (gnt0_w && bus.lock0) || (gnt1_w && bus.lock1);
  assign cnt_inc      = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (granted_lock && (BURST_MAX > 1)) begin
          state_d     = gnt0_w ? OWN0 : OWN1;
          burst_cnt_d = 4'd1;
        end else begin
          burst_cnt_d = 4'd0;
        end
      end
      OWN0, OWN1: begin
        if (owner_hold) begin
          burst_cnt_d = cnt_inc;
          // A full burst forces release; last_q then points at the owner so the other side wins.
          if (!granted_lock || (cnt_inc >= BURST_LIM)) begin
            state_d     = IDLE;
            burst_cnt_d = 4'd0;
          end
        end else begin
          state_d     = IDLE;
          burst_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = 4'd0;
      end
    endcase
    if (gnt0_w) begin
      last_d = 1'b0;
    end else if (gnt1_w) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign mem_addr_w = gnt0_w ? bus.addr0 : (gnt1_w ? bus.addr1 : '0);

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (mem_addr_w[1:0] != 2'b00);
  assign resp_word  = misaligned ? '0 : bus.mem_rdata;
  assign err_d      = (gnt0_w || gnt1_w) && misaligned;
`else
  assign resp_word  = bus.mem_rdata;
  assign err_d      = 1'b0;
`endif

  // Response stage: the word seen during the grant cycle is presented one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      rvalid0_q <= gnt0_w;
      rvalid1_q <= gnt1_w;
      err_q     <= err_d;
      if (gnt0_w) begin
        rdata0_q <= resp_word;
      end
      if (gnt1_w) begin
        rdata1_q <= resp_word;
      end
    end
  end

  assign bus.gnt0     = gnt0_w;
  assign bus.gnt1     = gnt1_w;
  assign bus.mem_addr = mem_addr_w;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed and randomized bench for imem_port_arbiter against an ownership/turn reference model.
module tb_imem_port_arbiter;
  localparam int BURST_MAX = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) io();

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(BURST_MAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (io)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'h2002, a[17:2] + 16'd8};
  endfunction

  function automatic logic [31:0] resp_of(input logic [31:0] a);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return 32'h0;
`endif
    return mem_word(a);
  endfunction

  function automatic logic err_of(input logic [31:0] a);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  assign io.mem_rdata = mem_word(io.mem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the port, how many grants in the current run, whose turn it was last.
  int owner = -1;
  int streak = 0;
  int mlast = 1;
  int mg = -1;
  int dut_g = -1;
  logic        exp_rv0 = 1'b0, exp_rv1 = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rn,
                       input logic r0, input logic [31:0] a0, input logic l0,
                       input logic r1, input logic [31:0] a1, input logic l1);
    int   g;
    logic r[2];
    logic lk[2];
    reset_n  = rn;
    io.req0  = r0; io.addr0 = a0; io.lock0 = l0;
    io.req1  = r1; io.addr1 = a1; io.lock1 = l1;
    r[0] = r0; r[1] = r1; lk[0] = l0; lk[1] = l1;
    if (!rn) begin
      owner = -1; streak = 0; mlast = 1;
      exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = '0; exp_rd1 = '0; exp_err = 1'b0;
    end
    @(negedge clk);
    if (!rn)                        g = -1;
    else if (owner >= 0 && r[owner]) g = owner;
    else if (r0 && r1)              g = 1 - mlast;
    else if (r0)                    g = 0;
    else if (r1)                    g = 1;
    else                            g = -1;
    dut_g = io.gnt0 ? 0 : (io.gnt1 ? 1 : -1);
    check("gnt0",     {31'b0, io.gnt0}, {31'b0, g == 0});
    check("gnt1",     {31'b0, io.gnt1}, {31'b0, g == 1});
    check("mem_addr", io.mem_addr, (g == 0) ? a0 : ((g == 1) ? a1 : 32'h0));
    check("rvalid0",  {31'b0, io.rvalid0}, {31'b0, exp_rv0});
    check("rvalid1",  {31'b0, io.rvalid1}, {31'b0, exp_rv1});
    check("rdata0",   io.rdata0, exp_rd0);
    check("rdata1",   io.rdata1, exp_rd1);
    check("err",      {31'b0, io.err}, {31'b0, exp_err});
    if (rn) begin
      if (owner >= 0 && r[owner]) begin
        streak++;
        if (!lk[owner] || streak >= BURST_MAX) begin owner = -1; streak = 0; end
      end else if (owner >= 0) begin
        owner = -1; streak = 0;
      end else if (g >= 0 && lk[g] && BURST_MAX > 1) begin
        owner = g; streak = 1;
      end
      if (g >= 0) mlast = g;
      exp_rv0 = (g == 0);
      exp_rv1 = (g == 1);
      if (g == 0) exp_rd0 = resp_of(a0);
      if (g == 1) exp_rd1 = resp_of(a1);
      exp_err = (g == 0) ? err_of(a0) : ((g == 1) ? err_of(a1) : 1'b0);
    end
    mg = g;
    @(posedge clk);
    #1;
  endtask

  logic        p0, p1, l0, l1, rn;
  logic [31:0] ra0, ra1;

  initial begin
    // Reset state with requests present: no grant, zero address, idle response.
    drive(0, 1, 32'h4, 1, 1, 32'h8, 1);
    drive(0, 1, 32'h4, 1, 1, 32'h8, 1);

    // Single fetch read with 1-cycle registered response.
    drive(1, 1, 32'h8, 0, 0, 32'h0, 0);
    check("t1_gnt", 32'(dut_g), 32'd0);
    check("t1_rvalid0", {31'b0, io.rvalid0}, 32'd1);
    check("t1_rdata0", io.rdata0, 32'h2002000A);
    check("t1_rvalid1", {31'b0, io.rvalid1}, 32'd0);
    drive(1, 0, 32'h0, 0, 0, 32'h0, 0);

    // Alternation from reset with both requesting and no lock.
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h100 + 32'(4*i), 0, 1, 32'h200 + 32'(4*i), 0);
      check("t2_alt", 32'(dut_g), 32'(i % 2));
    end
    drive(1, 0, 32'h0, 0, 0, 32'h0, 0);

    // Locked burst by requester 1 bounded at BURST_MAX, then requester 0 wins.
    drive(1, 1, 32'h40, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'h44, 0, 1, 32'h80 + 32'(4*i), 1);
      check("t3_burst", 32'(dut_g), (i < 4) ? 32'd1 : 32'd0);
    end
    drive(1, 0, 32'h0, 0, 0, 32'h0, 0);

    // Owner drops its request: the other side gets the port in the same cycle.
    drive(1, 1, 32'h10, 1, 0, 32'h0, 0);
    drive(1, 0, 32'h0, 0, 1, 32'h20, 0);
    check("t4_drop", 32'(dut_g), 32'd1);
    drive(1, 1, 32'h14, 0, 1, 32'h24, 0);
    drive(1, 0, 32'h0, 0, 1, 32'h24, 0);
    drive(1, 0, 32'h0, 0, 0, 32'h0, 0);

    // Reset right after a grant drops the response; first grant afterwards goes to 0.
    drive(1, 1, 32'h30, 0, 0, 32'h0, 0);
    drive(0, 1, 32'h34, 0, 1, 32'h38, 0);
    check("t5_rvalid0_rst", {31'b0, io.rvalid0}, 32'd0);
    drive(0, 1, 32'h34, 0, 1, 32'h38, 0);
    drive(1, 1, 32'h34, 0, 1, 32'h38, 0);
    check("t5_first", 32'(dut_g), 32'd0);
    drive(1, 0, 32'h0, 0, 1, 32'h38, 0);
    drive(1, 0, 32'h0, 0, 0, 32'h0, 0);

    // Misaligned fetch address.
    drive(1, 1, 32'h6, 0, 0, 32'h0, 0);
    check("t6_rvalid0", {31'b0, io.rvalid0}, 32'd1);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    check("t6_rdata0", io.rdata0, 32'h0);
    check("t6_err", {31'b0, io.err}, 32'd1);
`else
    check("t6_rdata0", io.rdata0, mem_word(32'h6));
    check("t6_err", {31'b0, io.err}, 32'd0);
`endif
    drive(1, 0, 32'h0, 0, 0, 32'h0, 0);

    // Random traffic obeying the hold-until-granted rule.
    p0 = 1'b0; p1 = 1'b0; ra0 = '0; ra1 = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1;
        ra0 = $urandom & 32'h0003_FFFF;
        if ($urandom_range(0, 7) != 0) ra0[1:0] = 2'b00;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1;
        ra1 = $urandom & 32'h0003_FFFF;
        if ($urandom_range(0, 7) != 0) ra1[1:0] = 2'b00;
      end
      l0 = 1'($urandom_range(0, 1));
      l1 = 1'($urandom_range(0, 1));
      rn = ($urandom_range(0, 299) != 0);
      drive(rn, p0, ra0, l0, p1, ra1, l1);
      if (mg == 0) p0 = 1'b0;
      if (mg == 1) p1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
